instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Initiator side of the instruction-memory read interface.
- Holds the program counter and drives the word-aligned byte address to instruction memory.
- Memory returns the instruction combinationally in the same cycle.
- Captures {instruction, pc, pc+4} into an IF/ID output register with a valid/ready handshake toward decode.
- Supports stall (backpressure), branch/jump redirect with flush, and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
- MEM_WORDS, 256, instruction memory depth in 32-bit words (used only by the optional bounds check).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; always equals the pc register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  new PC; bits [1:0] are ignored and forced to 0.
- halt  input  1  stop fetching after the current cycle.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts the IF/ID register this cycle.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  address of out_instr.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
- halted  output  1  FSM is in HALT.
- fetch_count  output  32  number of instructions captured since reset; wraps modulo 2^32.
- fetch_fault  output  1  out-of-range fetch detected; tied to 0 unless FETCH_BOUNDS_CHECK_EN is defined.

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - pc=RESET_PC, state=BOOT.
  - out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0.
  - halted=0, fetch_count=0, fetch_fault=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one idle cycle after reset release; no capture; then RUN.
  - RUN: normal fetch.
  - RUN -> HALT when halt=1 and redirect_valid=0.
  - HALT -> RUN on redirect_valid=1.
  - In HALT: halted=1, no capture, pc frozen. The held out_valid entry stays until consumed by out_ready.
- slot_free = !out_valid || out_ready.
- Capture in RUN when slot_free and !redirect_valid:
  - out_instr<=imem_instr, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1.
  - pc<=pc+4, fetch_count+=1.
  - Latency: address to out_valid is one cycle.
- Stall (RUN, !slot_free): pc and the output register hold; imem_addr is stable.
- Consume without capture (out_ready=1 while halt=1, or in HALT/BOOT): out_valid<=0 next cycle.
- Redirect (any state except BOOT):
  - Has priority over halt and over capture.
  - pc<={redirect_target[31:2],2'b00}.
  - out_valid<=0 next cycle regardless of out_ready (flush); no capture and no fetch_count increment that cycle.
- Simultaneous redirect and halt: redirect wins, state=RUN.
- PC arithmetic: 32-bit unsigned; 32'hFFFF_FFFC+4 wraps to 0.
- imem_addr is combinational from the pc register only; no combinational path from any input.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - In RUN, if pc[31:2] >= MEM_WORDS when a capture would occur: no capture, fetch_fault<=1 (sticky until reset), state->HALT.
  - A redirect clears the halt but not fetch_fault.
- Undefined: fetch_fault tied to 0, no check logic; addresses alias per memory decoding.

Decomposition:
- Package mips_fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - Constants ADDR_W=32, INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0000_0000.
- One sub-module: fetch_pipe_reg, the IF/ID output register with valid/ready/flush. It instantiates cleanly and is reused for later pipeline stages.

Test Plan:
- Memory words 0..3 = 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000. Reset, out_ready=1 -> BOOT for 1 cycle, then out_pc 0,4,8,12 on consecutive cycles with matching instructions; fetch_count=4.
- Hold out_ready=0 for 3 cycles with out_pc=4 -> out_instr stays 0x20090003 and imem_addr stays 8. Release -> next out_pc=8.
- Redirect to 0x00000041 while out_valid=1, out_ready=0 -> next cycle out_valid=0. Following cycle out_pc=0x40, out_pc_plus4=0x44.
- Assert halt -> halted=1, imem_addr frozen. Pending entry drains on out_ready. Redirect to 0 -> RUN, out_pc=0.
- Assert reset mid-stall with out_valid=1 -> all outputs zero immediately, before the next clk edge.
- With FETCH_BOUNDS_CHECK_EN and MEM_WORDS=4, run from 0 -> fetches at 0..12 complete; at pc=16, fetch_fault=1, halted=1, no capture, fetch_count=4.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_fetch_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_pipe_reg.sv
// Generic pipeline register with valid/ready handshake and flush.
// Flush beats load, and load beats a plain consume.
module fetch_pipe_reg #(
    parameter int unsigned       DataW    = 32,
    parameter logic [DataW-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DataW-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DataW-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;

    assign in_ready_o = !valid_q || out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= ResetVal;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, BOOT/RUN/HALT control and IF/ID register.
// Define FETCH_BOUNDS_CHECK_EN to fault and halt on fetches beyond MEM_WORDS.
module instruction_fetch
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus4,
    output logic               halted,
    output logic [31:0]        fetch_count,
    output logic               fetch_fault
);

    localparam int unsigned PipeW = INSTR_W + 2 * ADDR_W;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       count_q, count_d;
    logic              slot_free;
    logic              fetch_go;
    logic              in_range;
    logic              capture;
    logic              flush;
    logic [PipeW-1:0]  pipe_in, pipe_out;

`ifdef FETCH_BOUNDS_CHECK_EN
    logic fault_q, fault_d;
    assign in_range    = {2'b00, pc_q[ADDR_W-1:2]} < MEM_WORDS;
    assign fetch_fault = fault_q;
`else
    logic unused_mem_words;
    assign unused_mem_words = ^MEM_WORDS;
    assign in_range         = 1'b1;
    assign fetch_fault      = 1'b0;
`endif

    // A fetch is attempted only in RUN with a free slot and no redirect or halt.
    assign fetch_go = (state_q == RUN) && slot_free && !redirect_valid && !halt;
    assign capture  = fetch_go && in_range;
    assign flush    = redirect_valid && (state_q != BOOT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
`ifdef FETCH_BOUNDS_CHECK_EN
        fault_d = fault_q;
`endif
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    pc_d = align_word(redirect_target);
                end else if (halt) begin
                    state_d = HALT;
                end else if (capture) begin
                    pc_d    = pc_q + PC_STEP;
                    count_d = count_q + 32'd1;
                end
`ifdef FETCH_BOUNDS_CHECK_EN
                else if (fetch_go) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end
`endif
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_d    = align_word(redirect_target);
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
`ifdef FETCH_BOUNDS_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign pipe_in = {imem_instr, pc_q, pc_q + PC_STEP};

    fetch_pipe_reg #(
        .DataW    (PipeW),
        .ResetVal ({NOP_INSTR, {(2 * ADDR_W){1'b0}}})
    ) u_if_id (
        .clk_i       (clk),
        .rst_i       (reset),
        .flush_i     (flush),
        .in_valid_i  (capture),
        .in_ready_o  (slot_free),
        .in_data_i   (pipe_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (pipe_out)
    );

    assign out_instr    = pipe_out[PipeW-1 -: INSTR_W];
    assign out_pc       = pipe_out[2*ADDR_W-1 -: ADDR_W];
    assign out_pc_plus4 = pipe_out[ADDR_W-1:0];

    assign imem_addr   = pc_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pc_plus4;
    logic        halted;
    logic [31:0] fetch_count;
    logic        fetch_fault;

    logic [31:0] mem [256];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[9:2]];

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (256)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .halted          (halted),
        .fetch_count     (fetch_count),
        .fetch_fault     (fetch_fault)
    );

`ifdef FETCH_BOUNDS_CHECK_EN
    logic        b_reset;
    logic [31:0] b_addr, b_instr, b_out_instr, b_out_pc, b_out_pc4, b_count;
    logic        b_valid, b_halted, b_fault;

    assign b_instr = mem[b_addr[9:2]];

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (4)
    ) dut_bounds (
        .clk             (clk),
        .reset           (b_reset),
        .imem_addr       (b_addr),
        .imem_instr      (b_instr),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .halt            (1'b0),
        .out_valid       (b_valid),
        .out_ready       (1'b1),
        .out_instr       (b_out_instr),
        .out_pc          (b_out_pc),
        .out_pc_plus4    (b_out_pc4),
        .halted          (b_halted),
        .fetch_count     (b_count),
        .fetch_fault     (b_fault)
    );
`endif

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] tgt;
        logic        hlt;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_addr;
        logic [31:0] exp_count;
        logic        exp_halted;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(logic rdy, logic redir, logic [31:0] tgt, logic hlt,
                                logic ev, logic cd, logic [31:0] pc, logic [31:0] ins,
                                logic [31:0] addr, logic [31:0] cnt, logic eh);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.tgt = tgt; v.hlt = hlt;
        v.exp_valid = ev; v.chk_data = cd; v.exp_pc = pc; v.exp_instr = ins;
        v.exp_addr = addr; v.exp_count = cnt; v.exp_halted = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            out_ready       = vecs[i].rdy;
            redirect_valid  = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            halt            = vecs[i].hlt;
            step();
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].exp_count);
            chk($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].exp_halted});
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d out_instr", i), out_instr, vecs[i].exp_instr);
                chk($sformatf("v%0d out_pc_plus4", i), out_pc_plus4, vecs[i].exp_pc + 32'd4);
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " out_instr"}, out_instr, 32'd0);
        chk({tag, " out_pc"}, out_pc, 32'd0);
        chk({tag, " out_pc_plus4"}, out_pc_plus4, 32'd0);
        chk({tag, " imem_addr"}, imem_addr, 32'd0);
        chk({tag, " fetch_count"}, fetch_count, 32'd0);
        chk({tag, " halted"}, {31'b0, halted}, 32'd0);
        chk({tag, " fetch_fault"}, {31'b0, fetch_fault}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        mem[3] = 32'hAC0A_0000;

        //          rdy rd tgt            h  ev cd pc            instr          addr           cnt h
        vecs[0]  = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,         32'h0,         0, 0);
        vecs[1]  = mk(1, 0, 32'h0,        0, 1, 1, 32'h0,        32'h2008_0005, 32'h4,         1, 0);
        vecs[2]  = mk(1, 0, 32'h0,        0, 1, 1, 32'h4,        32'h2009_0003, 32'h8,         2, 0);
        vecs[3]  = mk(1, 0, 32'h0,        0, 1, 1, 32'h8,        32'h0109_5020, 32'hC,         3, 0);
        vecs[4]  = mk(1, 0, 32'h0,        0, 1, 1, 32'hC,        32'hAC0A_0000, 32'h10,        4, 0);
        vecs[5]  = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,         32'h0,         0, 0);
        vecs[6]  = mk(1, 0, 32'h0,        0, 1, 1, 32'h0,        32'h2008_0005, 32'h4,         1, 0);
        vecs[7]  = mk(1, 0, 32'h0,        0, 1, 1, 32'h4,        32'h2009_0003, 32'h8,         2, 0);
        vecs[8]  = mk(0, 0, 32'h0,        0, 1, 1, 32'h4,        32'h2009_0003, 32'h8,         2, 0);
        vecs[9]  = mk(0, 0, 32'h0,        0, 1, 1, 32'h4,        32'h2009_0003, 32'h8,         2, 0);
        vecs[10] = mk(0, 0, 32'h0,        0, 1, 1, 32'h4,        32'h2009_0003, 32'h8,         2, 0);
        vecs[11] = mk(1, 0, 32'h0,        0, 1, 1, 32'h8,        32'h0109_5020, 32'hC,         3, 0);
        vecs[12] = mk(0, 1, 32'h41,       0, 0, 0, 32'h0,        32'h0,         32'h40,        3, 0);
        vecs[13] = mk(0, 0, 32'h0,        0, 1, 1, 32'h40,       32'h1000_0010, 32'h44,        4, 0);
        vecs[14] = mk(0, 0, 32'h0,        1, 1, 1, 32'h40,       32'h1000_0010, 32'h44,        4, 1);
        vecs[15] = mk(0, 0, 32'h0,        0, 1, 1, 32'h40,       32'h1000_0010, 32'h44,        4, 1);
        vecs[16] = mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,         32'h44,        4, 1);
        vecs[17] = mk(1, 1, 32'h0,        0, 0, 0, 32'h0,        32'h0,         32'h0,         4, 0);
        vecs[18] = mk(1, 0, 32'h0,        0, 1, 1, 32'h0,        32'h2008_0005, 32'h4,         5, 0);
        vecs[19] = mk(1, 1, 32'h20,       1, 0, 0, 32'h0,        32'h0,         32'h20,        5, 0);
        vecs[20] = mk(1, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0,         32'h20,        5, 1);

        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        redirect_target = 32'h0; halt = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
        b_reset = 1'b1;
`endif
        #1;
        chk_zero_outputs("reset");
        step();
        reset = 1'b0;

        // Straight-line fetch of four words.
        run_vecs(0, 4);

        // Stall, then async reset with a valid entry held.
        out_ready = 1'b0;
        step();
        chk("stall out_valid", {31'b0, out_valid}, 32'd1);
        chk("stall out_pc", out_pc, 32'hC);
        #2;
        reset = 1'b1;
        #1;
        chk_zero_outputs("midreset");
        step();
        reset = 1'b0;

        // Backpressure, redirect flush, halt/drain, redirect out of halt.
        run_vecs(5, 20);

        // Redirect with misaligned target near top of memory, then wrap of pc+4.
        halt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step();
        chk("wrap redir addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap redir halted", {31'b0, halted}, 32'd0);
        redirect_valid = 1'b0;
        step();
        chk("wrap out_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap out_pc_plus4", out_pc_plus4, 32'h0);
        chk("wrap out_instr", out_instr, 32'h1000_00FF);
        chk("wrap imem_addr", imem_addr, 32'h0);
        chk("wrap fetch_count", fetch_count, 32'd6);

`ifdef FETCH_BOUNDS_CHECK_EN
        b_reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("bounds last pc", b_out_pc, 32'hC);
        chk("bounds count4", b_count, 32'd4);
        chk("bounds no fault yet", {31'b0, b_fault}, 32'd0);
        step();
        chk("bounds fault", {31'b0, b_fault}, 32'd1);
        chk("bounds halted", {31'b0, b_halted}, 32'd1);
        chk("bounds no capture", {31'b0, b_valid}, 32'd0);
        chk("bounds count", b_count, 32'd4);
        chk("bounds addr", b_addr, 32'h10);
`else
        chk("fault tied low", {31'b0, fetch_fault}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
